node_input_arbiter: RTL and testbench

- Shares the single 4-bit input channel of one processing node between NREQ requesters, e.g. the neighbour links A–D.
- Arbitration is round-robin; each grant covers one burst, ended by a last flag, a length cap or a stall timeout.
- Each word is staged in a one-entry output register and driven to the node with a valid/ready handshake.
- Sits between the node-grid link logic and a node instance, inside the top-level wrapper.

---
 rtl/node_input_arbiter.sv | 157 +++++++++++++++
 tb/tb_node_input_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/node_input_arbiter.sv
// Round-robin arbiter that shares one node input channel between NREQ requesters.
// Each grant covers one burst (last flag, length cap or stall timeout); words are staged in a one-entry output register.
module node_input_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned STALL_TO  = 8,
  localparam int unsigned IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              node_valid,
  output logic [DW-1:0]     node_data,
  input  logic              node_ready,
  output logic [IW-1:0]     node_src,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            node_valid_q, node_valid_d;
  logic [DW-1:0]   node_data_q, node_data_d;
  logic [IW-1:0]   node_src_q, node_src_d;

  logic            slot_free;
  logic            accept;
  logic            found;
  logic [IW-1:0]   pick;
  logic [DW-1:0]   gdata;
  int unsigned     idx;

  // The output slot can take a new word when empty or when it drains this cycle.
  assign slot_free = !node_valid_q || node_ready;
  assign accept    = (state_q == GRANT) && req_valid[gidx_q] && slot_free;
  assign gdata     = req_data[gidx_q*DW +: DW];

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT) begin
      req_ready[gidx_q] = slot_free;
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_q) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_d         = rr_q;
    burst_d      = burst_q;
    stall_d      = stall_q;
    node_valid_d = node_valid_q;
    node_data_d  = node_data_q;
    node_src_d   = node_src_q;

    if (accept) begin
      node_valid_d = 1'b1;
      node_data_d  = gdata;
      node_src_d   = gidx_q;
    end else if (node_valid_q && node_ready) begin
      node_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[pick]    = 1'b1;
          gidx_d           = pick;
          burst_d          = '0;
          stall_d          = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_d = burst_q + 1'b1;
          stall_d = '0;
          if (req_last[gidx_q] || (32'(burst_q) + 32'd1 == MAX_BURST)) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = IW'((32'(gidx_q) + 32'd1) % NREQ);
          end
        end else if (!req_valid[gidx_q]) begin
          if (32'(stall_q) == STALL_TO - 1) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = IW'((32'(gidx_q) + 32'd1) % NREQ);
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_q         <= '0;
      burst_q      <= '0;
      stall_q      <= '0;
      node_valid_q <= 1'b0;
      node_data_q  <= '0;
      node_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_q         <= rr_d;
      burst_q      <= burst_d;
      stall_q      <= stall_d;
      node_valid_q <= node_valid_d;
      node_data_q  <= node_data_d;
      node_src_q   <= node_src_d;
    end
  end

  assign node_valid = node_valid_q;
  assign node_data  = node_data_q;
  assign node_src   = node_src_q;
  assign grant      = grant_q;
  assign busy       = (state_q == GRANT);

endmodule

// File: tb/tb_node_input_arbiter.sv
// Directed testbench for node_input_arbiter with hand-computed expectations.
module tb_node_input_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        node_valid;
  logic [3:0]  node_data;
  logic        node_ready;
  logic [1:0]  node_src;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  d [4];

  int checks = 0;
  int errors = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  node_input_arbiter #(
    .NREQ(4), .DW(4), .MAX_BURST(4), .STALL_TO(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .node_valid(node_valid),
    .node_data(node_data), .node_ready(node_ready), .node_src(node_src),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_last   = '0;
    node_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (node_valid !== 1'b0) begin errors++; $display("FAIL reset_node_valid got=%b exp=0", node_valid); end
    checks++; if (node_data !== 4'h0) begin errors++; $display("FAIL reset_node_data got=%h exp=0", node_data); end
    checks++; if (node_src !== 2'd0) begin errors++; $display("FAIL reset_node_src got=%0d exp=0", node_src); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    apply_reset();
    req_valid = 4'b0100; d[2] = 4'h1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sb_idle_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL sb_grant got=%b exp=0100", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sb_req_ready got=%b exp=0100", req_ready); end
    checks++; if (node_valid !== 1'b0) begin errors++; $display("FAIL sb_nv_c1 got=%b exp=0", node_valid); end
    tick();
    checks++; if (node_valid !== 1'b1 || node_data !== 4'h1 || node_src !== 2'd2) begin errors++; $display("FAIL sb_word1 got=%b/%h/%0d exp=1/1/2", node_valid, node_data, node_src); end
    d[2] = 4'h2;
    tick();
    checks++; if (node_data !== 4'h2 || node_src !== 2'd2) begin errors++; $display("FAIL sb_word2 got=%h/%0d exp=2/2", node_data, node_src); end
    d[2] = 4'h3; req_last = 4'b0100;
    tick();
    checks++; if (node_valid !== 1'b1 || node_data !== 4'h3) begin errors++; $display("FAIL sb_word3 got=%b/%h exp=1/3", node_valid, node_data); end
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL sb_release got=%b/%b exp=0000/0", grant, busy); end
    // rr now points at 3, so requester 3 must beat requester 0.
    req_valid = 4'b1001; req_last = 4'b1001; d[0] = 4'h5; d[3] = 4'h6;
    tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL sb_rr_grant got=%b exp=1000", grant); end
    checks++; if (node_valid !== 1'b0) begin errors++; $display("FAIL sb_drain got=%b exp=0", node_valid); end
    tick();
    checks++; if (node_data !== 4'h6 || node_src !== 2'd3 || grant !== 4'b0000) begin errors++; $display("FAIL sb_rr_word got=%h/%0d/%b exp=6/3/0000", node_data, node_src, grant); end
    req_valid = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sb_rr_next got=%b exp=0001", grant); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 4'(8 + i);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (grant !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, 4'(1 << (k % 4))); end
      tick();
      checks++; if (node_src !== 2'(k % 4) || node_data !== 4'(8 + k % 4) || grant !== 4'b0000) begin errors++; $display("FAIL rr_word%0d got=%0d/%h/%b exp=%0d/%h/0000", k, node_src, node_data, grant, k % 4, 8 + k % 4); end
    end
  endtask

  task automatic test_burst_cap();
    logic [3:0] exp_d [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [1:0] exp_s [11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    int         exp_g [4]  = '{1, 2, 1, 1};
    logic [3:0] got_d [16];
    logic [1:0] got_s [16];
    int         got_g [8];
    int         n = 0;
    int         ng = 0;
    int         w1 = 0;
    logic       acc1, acc2;
    logic [3:0] prev_g;
    apply_reset();
    req_valid = 4'b0110; req_last = 4'b0100; d[1] = 4'h1; d[2] = 4'hE;
    for (int c = 0; c < 30; c++) begin
      acc1 = req_valid[1] && req_ready[1];
      acc2 = req_valid[2] && req_ready[2];
      if (node_valid && node_ready && n < 16) begin
        got_d[n] = node_data; got_s[n] = node_src; n++;
      end
      prev_g = grant;
      tick();
      if (grant != 4'b0000 && prev_g == 4'b0000 && ng < 8) begin
        for (int i = 0; i < 4; i++) if (grant[i]) got_g[ng] = i;
        ng++;
      end
      if (acc1) begin
        w1++;
        if (w1 == 10) req_valid[1] = 1'b0;
        else d[1] = 4'(w1 + 1);
      end
      if (acc2) req_valid[2] = 1'b0;
    end
    checks++; if (n !== 11) begin errors++; $display("FAIL cap_word_count got=%0d exp=11", n); end
    for (int i = 0; i < 11; i++) begin
      if (i < n) begin
        checks++; if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin errors++; $display("FAIL cap_word%0d got=%h/%0d exp=%h/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]); end
      end
    end
    checks++; if (ng !== 4) begin errors++; $display("FAIL cap_grant_count got=%0d exp=4", ng); end
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        checks++; if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL cap_grant%0d got=%0d exp=%0d", i, got_g[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'b0001; d[0] = 4'h3;
    tick();
    tick();
    checks++; if (node_valid !== 1'b1 || node_data !== 4'h3) begin errors++; $display("FAIL bp_first got=%b/%h exp=1/3", node_valid, node_data); end
    d[0] = 4'h5; node_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low got=%b exp=0000", req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (node_valid !== 1'b1 || node_data !== 4'h3 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/3/0000", k, node_valid, node_data, req_ready); end
    end
    node_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume_ready got=%b exp=0001", req_ready); end
    tick();
    checks++; if (node_valid !== 1'b1 || node_data !== 4'h5 || node_src !== 2'd0) begin errors++; $display("FAIL bp_next got=%b/%h/%0d exp=1/5/0", node_valid, node_data, node_src); end
  endtask

  task automatic test_stall_timeout();
    apply_reset();
    req_valid = 4'b1001; req_last = 4'b1000; d[0] = 4'h6; d[3] = 4'hC;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL st_grant got=%b exp=0001", grant); end
    tick();
    checks++; if (node_data !== 4'h6 || grant !== 4'b0001) begin errors++; $display("FAIL st_word got=%h/%b exp=6/0001", node_data, grant); end
    req_valid[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL st_hold%0d got=%b exp=0001", k, grant); end
    end
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL st_release got=%b/%b exp=0000/0", grant, busy); end
    tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL st_next got=%b exp=1000", grant); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 4'b0010; d[1] = 4'h5; node_ready = 1'b0;
    tick();
    tick();
    checks++; if (node_valid !== 1'b1 || grant !== 4'b0010) begin errors++; $display("FAIL ar_pre got=%b/%b exp=1/0010", node_valid, grant); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL ar_grant got=%b/%b exp=0000/0", grant, busy); end
    checks++; if (node_valid !== 1'b0 || req_ready !== 4'b0000 || node_data !== 4'h0) begin errors++; $display("FAIL ar_out got=%b/%b/%h exp=0/0000/0", node_valid, req_ready, node_data); end
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111; node_ready = 1'b1;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ar_restart got=%b exp=0001", grant); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_stall_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
